hicore_icb_arbt: RTL and testbench
==================================

Name: hicore_icb_arbt

Overview:
- N-to-1 ICB arbiter sitting directly upstream of the ICB splitter.
- Merges ARBT_NUM master ICB ports (IFU, LSU, debug, ...) into one ICB command/response channel that feeds the splitter's input.
- Round-robin grant with lock while a command is stalled.
- An outstanding-ID FIFO routes each in-order response back to the master that issued the command.

Parameters:
- AW, 32, address width
- DW, 32, data width; wmask width is DW/8
- ARBT_NUM, 4, number of master ports; legal range >=2
- ARBT_PTR_W, 2, width of master index; must satisfy 2^ARBT_PTR_W >= ARBT_NUM
- OUTS_DEPTH, 2, outstanding-ID FIFO depth; legal range >=1

Ports:
- clk  input  1  clock
- rst  input  1  reset; one clock, reset is synchronous and active-high
- i_bus_icb_cmd_valid  input  ARBT_NUM  per-master command valid
- i_bus_icb_cmd_ready  output  ARBT_NUM  per-master command ready
- i_bus_icb_cmd_read  input  ARBT_NUM  per-master read flag
- i_bus_icb_cmd_addr  input  ARBT_NUM*AW  packed addresses; master k at bits [(k+1)*AW-1:k*AW]
- i_bus_icb_cmd_wdata  input  ARBT_NUM*DW  packed write data
- i_bus_icb_cmd_wmask  input  ARBT_NUM*DW/8  packed byte masks
- i_bus_icb_rsp_valid  output  ARBT_NUM  per-master response valid
- i_bus_icb_rsp_ready  input  ARBT_NUM  per-master response ready
- i_bus_icb_rsp_err  output  ARBT_NUM  per-master error
- i_bus_icb_rsp_rdata  output  ARBT_NUM*DW  packed read data; the same o_icb_rsp_rdata value is broadcast to every master
- o_icb_cmd_valid  output  1  merged command valid
- o_icb_cmd_ready  input  1  downstream ready
- o_icb_cmd_read / o_icb_cmd_addr / o_icb_cmd_wdata / o_icb_cmd_wmask  output  1/AW/DW/DW/8  granted master's fields
- o_icb_rsp_valid  input  1  downstream response valid
- o_icb_rsp_ready  output  1  response ready to downstream
- o_icb_rsp_err  input  1  downstream response error
- o_icb_rsp_rdata  input  DW  downstream read data

Behaviour:
- State:
  - rr_ptr: ARBT_PTR_W bits; reset 0
  - lock: 1 bit; reset 0
  - lock_id: ARBT_PTR_W bits; reset 0
  - FIFO: OUTS_DEPTH entries of ARBT_PTR_W; rd/wr pointers and count; reset empty
- Grant:
  - If lock=1, the grant is lock_id.
  - Otherwise the grant is the first asserted valid scanning rr_ptr, rr_ptr+1, ... wrapping modulo ARBT_NUM. The scan is combinational.
- fifo_full: count == OUTS_DEPTH, computed from registered count only.
- o_icb_cmd_valid = (any request under grant) & ~fifo_full.
  - All command fields are muxed from the granted master.
  - With no valid request, fields are driven 0.
- i_bus_icb_cmd_ready[k] = (k == grant) & o_icb_cmd_ready & ~fifo_full. All other bits are 0.
- Lock behaviour:
  - If o_icb_cmd_valid=1 and o_icb_cmd_ready=0: next lock=1 and lock_id=grant. The grant cannot change while a command is stalled.
  - Lock clears on the handshake.
  - Masters must hold valid while stalled. A dropped valid under lock is a protocol violation; behaviour is unspecified.
- On a command handshake: push grant into the FIFO; rr_ptr <= (grant+1) mod ARBT_NUM; lock <= 0.
- Response path:
  - head = FIFO head entry.
  - i_bus_icb_rsp_valid[head] = o_icb_rsp_valid & ~fifo_empty. All other bits are 0.
  - o_icb_rsp_ready = i_bus_icb_rsp_ready[head] & ~fifo_empty.
  - i_bus_icb_rsp_err[k] = o_icb_rsp_err for all k; consumers must qualify it with valid.
- Pop on a response handshake (o_icb_rsp_valid & o_icb_rsp_ready).
- Empty FIFO: responses are never acknowledged; there is no bypass of a same-cycle command.
- Push and pop in the same cycle: count is unchanged and both pointers advance, wrapping modulo OUTS_DEPTH.
- Full FIFO with a same-cycle pop: the push is still blocked this cycle; it is accepted next cycle.
- Reset asserted mid-transaction:
  - All state returns to reset values on the next edge; outstanding IDs are discarded.
  - Outputs settle to valid=0/ready=0 because the FIFO is empty.
  - Downstream must also be reset.
- Latency: zero-cycle combinational command pass-through; responses are combinational via the registered head.

Test Plan:
1. Single master 2: valid, addr=0x1000_0004, o_icb_cmd_ready=1 -> same cycle o_icb_cmd_addr=0x1000_0004, i_bus_icb_cmd_ready=4'b0100; rr_ptr becomes 3; FIFO count 1. Response rdata=0xDEADBEEF -> i_bus_icb_rsp_valid=4'b0100.
2. All four masters valid continuously, ready=1, responses returned 1 cycle later -> grant order 0,1,2,3,0; responses route in the same order.
3. Masters 1 and 3 valid, o_icb_cmd_ready low for 3 cycles -> grant stays 1 for all stalled cycles despite master 3. After the handshake, the next grant is 3.
4. OUTS_DEPTH=2, issue 2 commands with no response -> third command sees o_icb_cmd_valid=0 and i_bus_icb_cmd_ready=0. Return one response -> third accepted one cycle later.
5. Response with o_icb_rsp_err=1 while the head master's rsp_ready=0 for 2 cycles -> o_icb_rsp_ready=0 and the FIFO holds. When ready rises, pop occurs and err is seen by that master.
6. Assert rst with 2 outstanding -> next cycle FIFO empty, rr_ptr=0, lock=0, o_icb_rsp_ready=0.

Source files
------------

// File: rtl/hicore_icb_arbt.sv
// N-to-1 ICB arbiter: round-robin grant with stall lock, plus an outstanding-ID FIFO
// that steers in-order responses back to the issuing master.
module hicore_icb_arbt #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int ARBT_NUM   = 4,
   parameter int ARBT_PTR_W = 2,
   parameter int OUTS_DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ARBT_NUM-1:0]        i_bus_icb_cmd_valid,
   output logic [ARBT_NUM-1:0]        i_bus_icb_cmd_ready,
   input  logic [ARBT_NUM-1:0]        i_bus_icb_cmd_read,
   input  logic [ARBT_NUM*AW-1:0]     i_bus_icb_cmd_addr,
   input  logic [ARBT_NUM*DW-1:0]     i_bus_icb_cmd_wdata,
   input  logic [ARBT_NUM*DW/8-1:0]   i_bus_icb_cmd_wmask,
   output logic [ARBT_NUM-1:0]        i_bus_icb_rsp_valid,
   input  logic [ARBT_NUM-1:0]        i_bus_icb_rsp_ready,
   output logic [ARBT_NUM-1:0]        i_bus_icb_rsp_err,
   output logic [ARBT_NUM*DW-1:0]     i_bus_icb_rsp_rdata,
   output logic                       o_icb_cmd_valid,
   input  logic                       o_icb_cmd_ready,
   output logic                       o_icb_cmd_read,
   output logic [AW-1:0]              o_icb_cmd_addr,
   output logic [DW-1:0]              o_icb_cmd_wdata,
   output logic [DW/8-1:0]            o_icb_cmd_wmask,
   input  logic                       o_icb_rsp_valid,
   output logic                       o_icb_rsp_ready,
   input  logic                       o_icb_rsp_err,
   input  logic [DW-1:0]              o_icb_rsp_rdata
);

   localparam int FW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
   localparam int CW = $clog2(OUTS_DEPTH + 1);
   localparam int MW = DW / 8;

   logic [ARBT_PTR_W-1:0] rr_ptr, lock_id, grant, cand, head;
   logic                  lock, found, req;
   logic                  fifo_full, fifo_empty, cmd_hsk, rsp_hsk;
   logic [ARBT_PTR_W-1:0] fifo_mem [OUTS_DEPTH];
   logic [FW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;

   // Locked grant is held while a stalled command waits; otherwise scan from rr_ptr.
   always_comb begin
      grant = lock_id;
      req   = 1'b0;
      found = 1'b0;
      cand  = '0;
      if (lock) begin
         req = i_bus_icb_cmd_valid[lock_id];
      end else begin
         grant = '0;
         for (int unsigned i = 0; i < ARBT_NUM; i++) begin
            cand = ARBT_PTR_W'((32'(rr_ptr) + i) % ARBT_NUM);
            if (!found && i_bus_icb_cmd_valid[cand]) begin
               found = 1'b1;
               grant = cand;
            end
         end
         req = found;
      end
   end

   always_comb begin
      o_icb_cmd_read  = 1'b0;
      o_icb_cmd_addr  = '0;
      o_icb_cmd_wdata = '0;
      o_icb_cmd_wmask = '0;
      if (req) begin
         o_icb_cmd_read  = i_bus_icb_cmd_read[grant];
         o_icb_cmd_addr  = i_bus_icb_cmd_addr[32'(grant)*AW +: AW];
         o_icb_cmd_wdata = i_bus_icb_cmd_wdata[32'(grant)*DW +: DW];
         o_icb_cmd_wmask = i_bus_icb_cmd_wmask[32'(grant)*MW +: MW];
      end
   end

   assign fifo_full       = (count == CW'(OUTS_DEPTH));
   assign fifo_empty      = (count == '0);
   assign o_icb_cmd_valid = req & ~fifo_full;
   assign cmd_hsk         = o_icb_cmd_valid & o_icb_cmd_ready;

   always_comb begin
      i_bus_icb_cmd_ready        = '0;
      i_bus_icb_cmd_ready[grant] = o_icb_cmd_ready & ~fifo_full;
   end

   assign head            = fifo_mem[rd_ptr];
   assign o_icb_rsp_ready = i_bus_icb_rsp_ready[head] & ~fifo_empty;
   assign rsp_hsk         = o_icb_rsp_valid & o_icb_rsp_ready;

   always_comb begin
      i_bus_icb_rsp_valid       = '0;
      i_bus_icb_rsp_valid[head] = o_icb_rsp_valid & ~fifo_empty;
   end

   assign i_bus_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
   assign i_bus_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr  <= '0;
         lock    <= 1'b0;
         lock_id <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (cmd_hsk) begin
            lock             <= 1'b0;
            rr_ptr           <= (grant == ARBT_PTR_W'(ARBT_NUM-1)) ? '0 : grant + ARBT_PTR_W'(1);
            fifo_mem[wr_ptr] <= grant;
            wr_ptr           <= (wr_ptr == FW'(OUTS_DEPTH-1)) ? '0 : wr_ptr + FW'(1);
         end else if (o_icb_cmd_valid) begin
            lock    <= 1'b1;
            lock_id <= grant;
         end
         if (rsp_hsk)
            rd_ptr <= (rd_ptr == FW'(OUTS_DEPTH-1)) ? '0 : rd_ptr + FW'(1);
         case ({cmd_hsk, rsp_hsk})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_hicore_icb_arbt.sv
// Directed bench for hicore_icb_arbt: grant order, stall lock, FIFO full/route, error path, reset.
module tb_hicore_icb_arbt;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   cmd_valid, cmd_ready, cmd_read;
   logic [127:0] cmd_addr, cmd_wdata;
   logic [15:0]  cmd_wmask;
   logic [3:0]   rsp_valid, rsp_ready, rsp_err;
   logic [127:0] rsp_rdata;
   logic         o_cmd_valid, o_cmd_ready, o_cmd_read;
   logic [31:0]  o_cmd_addr, o_cmd_wdata;
   logic [3:0]   o_cmd_wmask;
   logic         o_rsp_valid, o_rsp_ready, o_rsp_err;
   logic [31:0]  o_rsp_rdata;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_addr [4];

   always #5 clk = ~clk;

   hicore_icb_arbt #(.AW(32), .DW(32), .ARBT_NUM(4), .ARBT_PTR_W(2), .OUTS_DEPTH(2)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .i_bus_icb_cmd_valid (cmd_valid),
      .i_bus_icb_cmd_ready (cmd_ready),
      .i_bus_icb_cmd_read  (cmd_read),
      .i_bus_icb_cmd_addr  (cmd_addr),
      .i_bus_icb_cmd_wdata (cmd_wdata),
      .i_bus_icb_cmd_wmask (cmd_wmask),
      .i_bus_icb_rsp_valid (rsp_valid),
      .i_bus_icb_rsp_ready (rsp_ready),
      .i_bus_icb_rsp_err   (rsp_err),
      .i_bus_icb_rsp_rdata (rsp_rdata),
      .o_icb_cmd_valid     (o_cmd_valid),
      .o_icb_cmd_ready     (o_cmd_ready),
      .o_icb_cmd_read      (o_cmd_read),
      .o_icb_cmd_addr      (o_cmd_addr),
      .o_icb_cmd_wdata     (o_cmd_wdata),
      .o_icb_cmd_wmask     (o_cmd_wmask),
      .o_icb_rsp_valid     (o_rsp_valid),
      .o_icb_rsp_ready     (o_rsp_ready),
      .o_icb_rsp_err       (o_rsp_err),
      .o_icb_rsp_rdata     (o_rsp_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      exp_addr[0] = 32'hA000_0000;
      exp_addr[1] = 32'hB000_0000;
      exp_addr[2] = 32'h1000_0004;
      exp_addr[3] = 32'hC000_0000;
      cmd_addr    = {exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]};
      cmd_wdata   = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
      cmd_wmask   = 16'h8421;
      cmd_read    = 4'b0101;
      cmd_valid   = '0;
      rsp_ready   = '0;
      o_cmd_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rsp_err   = 1'b0;
      o_rsp_rdata = '0;
      rst         = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state: empty FIFO swallows nothing, no request drives zero fields
      o_rsp_valid = 1'b1; rsp_ready = 4'hF;
      #1;
      chk("rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
      chk("rst_cmd_addr", o_cmd_addr, 32'd0);
      chk("rst_rsp_ready", 32'(o_rsp_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);

      // test 1: single master 2
      @(negedge clk);
      o_rsp_valid = 1'b0; cmd_valid = 4'b0100; o_cmd_ready = 1'b1;
      #1;
      chk("t1_cmd_valid", 32'(o_cmd_valid), 32'd1);
      chk("t1_addr", o_cmd_addr, 32'h1000_0004);
      chk("t1_wdata", o_cmd_wdata, 32'h5555_0002);
      chk("t1_wmask", 32'(o_cmd_wmask), 32'h4);
      chk("t1_read", 32'(o_cmd_read), 32'd1);
      chk("t1_cmd_ready", 32'(cmd_ready), 32'b0100);
      @(negedge clk);
      cmd_valid = '0; o_rsp_valid = 1'b1; o_rsp_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t1_rsp_valid", 32'(rsp_valid), 32'b0100);
      chk("t1_rsp_rdata", rsp_rdata[64 +: 32], 32'hDEAD_BEEF);
      chk("t1_rsp_ready", 32'(o_rsp_ready), 32'd1);
      @(negedge clk);
      o_rsp_valid = 1'b0; cmd_valid = 4'b1001; o_cmd_ready = 1'b0;
      #1;
      chk("t1_rr_ptr3", o_cmd_addr, exp_addr[3]);
      @(negedge clk);
      rst = 1'b1; cmd_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // test 2: all masters valid, responses one cycle behind
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         cmd_valid   = (c < 5) ? 4'hF : 4'h0;
         o_cmd_ready = 1'b1;
         o_rsp_valid = (c >= 1);
         rsp_ready   = 4'hF;
         o_rsp_rdata = 32'h100 + 32'(c);
         #1;
         if (c < 5) begin
            chk("t2_grant", o_cmd_addr, exp_addr[c % 4]);
            chk("t2_cmd_ready", 32'(cmd_ready), 32'(4'b0001 << (c % 4)));
         end
         if (c >= 1)
            chk("t2_rsp_route", 32'(rsp_valid), 32'(4'b0001 << ((c - 1) % 4)));
      end

      // test 3: stall lock (rr_ptr is 1 here)
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         cmd_valid = 4'b1010; o_cmd_ready = 1'b0; o_rsp_valid = 1'b0;
         #1;
         chk("t3_stall_grant", o_cmd_addr, exp_addr[1]);
         chk("t3_stall_valid", 32'(o_cmd_valid), 32'd1);
         chk("t3_stall_ready", 32'(cmd_ready), 32'd0);
      end
      @(negedge clk);
      o_cmd_ready = 1'b1;
      #1;
      chk("t3_hsk_ready", 32'(cmd_ready), 32'b0010);
      @(negedge clk);
      o_cmd_ready = 1'b0;
      #1;
      chk("t3_next_grant", o_cmd_addr, exp_addr[3]);
      @(negedge clk);
      cmd_valid = 4'b1110;
      #1;
      chk("t3_lock_hold", o_cmd_addr, exp_addr[3]);
      @(negedge clk);
      o_cmd_ready = 1'b1;
      #1;
      chk("t3_lock_hsk", 32'(cmd_ready), 32'b1000);

      // test 4: FIFO full (IDs 1,3 outstanding)
      @(negedge clk);
      #1;
      chk("t4_full_valid", 32'(o_cmd_valid), 32'd0);
      chk("t4_full_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      o_rsp_valid = 1'b1; rsp_ready = 4'hF;
      #1;
      chk("t4_rsp_route", 32'(rsp_valid), 32'b0010);
      chk("t4_pop_blocks", 32'(o_cmd_valid), 32'd0);
      @(negedge clk);
      o_rsp_valid = 1'b0;
      #1;
      chk("t4_after_valid", 32'(o_cmd_valid), 32'd1);
      chk("t4_after_ready", 32'(cmd_ready), 32'b0010);

      // test 5: error response held while head master not ready (IDs 3,1 outstanding)
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         cmd_valid = '0; o_rsp_valid = 1'b1; o_rsp_err = 1'b1; rsp_ready = 4'b0111;
         #1;
         chk("t5_hold_ready", 32'(o_rsp_ready), 32'd0);
         chk("t5_hold_valid", 32'(rsp_valid), 32'b1000);
      end
      @(negedge clk);
      rsp_ready = 4'hF;
      #1;
      chk("t5_pop_ready", 32'(o_rsp_ready), 32'd1);
      chk("t5_err", 32'(rsp_err), 32'hF);
      @(negedge clk);
      o_rsp_err = 1'b0; rsp_ready = '0; cmd_valid = 4'b0001; o_cmd_ready = 1'b1;
      #1;
      chk("t5_next_head", 32'(rsp_valid), 32'b0010);
      chk("t5_no_ack", 32'(o_rsp_ready), 32'd0);
      chk("t5_grant0", 32'(cmd_ready), 32'b0001);

      // test 6: reset with two outstanding
      @(negedge clk);
      #1;
      chk("t6_full", 32'(o_cmd_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1; cmd_valid = '0; o_rsp_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0; o_rsp_valid = 1'b1; rsp_ready = 4'hF; cmd_valid = 4'hF; o_cmd_ready = 1'b0;
      #1;
      chk("t6_rsp_ready", 32'(o_rsp_ready), 32'd0);
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t6_cmd_valid", 32'(o_cmd_valid), 32'd1);
      chk("t6_rr_ptr0", o_cmd_addr, exp_addr[0]);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
